// File: rtl/dnn_arb_pkg.sv
// dnn_arb_pkg: shared types and helpers for the DNN write-request arbiter.
package dnn_arb_pkg;

   localparam int unsigned ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

   // Width of the PU id sent to the bridge: one bit wider than the index.
   function automatic int unsigned pu_id_width(input int unsigned num_pu);
      return $clog2(num_pu) + 1;
   endfunction

endpackage

// File: rtl/dnn_rr_arbiter.sv
// dnn_rr_arbiter: combinational round-robin pick of the first requester
// at or after the pointer, wrapping NUM_PU-1 -> 0.
module dnn_rr_arbiter
   import dnn_arb_pkg::*;
#(
   parameter int unsigned NUM_PU = 2,
   parameter int unsigned IDX_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1
)(
   input  logic [NUM_PU-1:0] i_req,
   input  logic [IDX_W-1:0]  i_ptr,
   output logic [NUM_PU-1:0] o_grant,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_valid
);

   logic [NUM_PU-1:0] w_rot;

   // Rotate the request vector so the pointer position lands on bit 0.
   assign w_rot = NUM_PU'({i_req, i_req} >> i_ptr);

   // First set bit of the rotated vector, mapped back to an absolute PU index.
   always_comb begin
      int unsigned v_sum;
      v_sum   = 0;
      o_valid = 1'b0;
      o_idx   = '0;
      o_grant = '0;
      for (int unsigned j = 0; j < NUM_PU; j++) begin
         if (!o_valid && w_rot[j]) begin
            o_valid = 1'b1;
            v_sum   = 32'(i_ptr) + j;
            if (v_sum >= NUM_PU) v_sum = v_sum - NUM_PU;
            o_idx   = IDX_W'(v_sum);
         end
      end
      if (o_valid) o_grant = NUM_PU'(1) << o_idx;
   end

endmodule

// File: rtl/dnn_wr_req_arbiter.sv
// dnn_wr_req_arbiter: shares the bridge write-request port among NUM_PU PUs.
// Round-robin grant, one write in flight, completion routed back to the owner.
// Optional wr_done watchdog enabled by defining DNN_WR_ARB_TIMEOUT_EN.
module dnn_wr_req_arbiter
   import dnn_arb_pkg::*;
#(
   parameter int unsigned NUM_PU         = 2,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TX_SIZE_WIDTH  = 10,
   parameter int unsigned PU_ID_W        = pu_id_width(NUM_PU),
   parameter int unsigned TIMEOUT_CYCLES = 4096
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PU-1:0]                 pu_wr_req,
   input  logic [NUM_PU*ADDR_W-1:0]          pu_wr_addr,
   input  logic [NUM_PU*TX_SIZE_WIDTH-1:0]   pu_wr_size,
   output logic [NUM_PU-1:0]                 pu_wr_ready,
   output logic [NUM_PU-1:0]                 pu_wr_done,
   output logic                              wr_req,
   output logic [PU_ID_W-1:0]                wr_pu_id,
   output logic [ADDR_W-1:0]                 wr_addr,
   output logic [TX_SIZE_WIDTH-1:0]          wr_req_size,
   input  logic                              wr_ready,
   input  logic                              wr_done,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int unsigned IDX_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic [IDX_W-1:0]          r_ptr;
   logic [IDX_W-1:0]          r_id;
   logic [ADDR_W-1:0]         r_addr;
   logic [TX_SIZE_WIDTH-1:0]  r_size;
   logic [NUM_PU-1:0]         r_done;

   logic [NUM_PU-1:0]         w_grant;
   logic [IDX_W-1:0]          w_grant_idx;
   logic                      w_grant_valid;
   logic [ADDR_W-1:0]         w_sel_addr;
   logic [TX_SIZE_WIDTH-1:0]  w_sel_size;
   logic                      w_accept;
   logic                      w_complete;

   function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
      return (32'(idx) >= NUM_PU - 1) ? '0 : idx + IDX_W'(1);
   endfunction

   dnn_rr_arbiter #(
      .NUM_PU (NUM_PU),
      .IDX_W  (IDX_W)
   ) u_rr (
      .i_req   (pu_wr_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_valid (w_grant_valid)
   );

   // Address/size of the granted PU.
   always_comb begin
      w_sel_addr = '0;
      w_sel_size = '0;
      for (int unsigned i = 0; i < NUM_PU; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = pu_wr_addr[i*ADDR_W +: ADDR_W];
            w_sel_size = pu_wr_size[i*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
         end
      end
   end

`ifdef DNN_WR_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout_err;
   logic             w_cnt_expired;
   logic             w_timeout;

   assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_timeout     = (r_state == WAIT_DONE) && !wr_done && w_cnt_expired;
   assign timeout_err   = r_timeout_err;

   // Watchdog: counts WAIT_DONE cycles from zero, error flag is sticky.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == WAIT_DONE && w_state_nxt == WAIT_DONE) r_cnt <= r_cnt + CNT_W'(1);
         else                                                  r_cnt <= '0;
         if (w_timeout) r_timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // Next-state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_accept = 1'b1;
               if (w_sel_size != '0) w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_ready) begin
               if (wr_done) begin
                  w_complete  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (wr_done) begin
               w_complete  = 1'b1;
               w_state_nxt = IDLE;
            end
`ifdef DNN_WR_ARB_TIMEOUT_EN
            else if (w_cnt_expired) begin
               w_complete  = 1'b1;
               w_state_nxt = IDLE;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Latch the accepted request, route the completion pulse, advance the pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr  <= '0;
         r_id   <= '0;
         r_addr <= '0;
         r_size <= '0;
         r_done <= '0;
      end else begin
         r_done <= '0;
         if (w_accept) begin
            r_id   <= w_grant_idx;
            r_addr <= w_sel_addr;
            r_size <= w_sel_size;
            if (w_sel_size == '0) begin
               r_done <= w_grant;
               r_ptr  <= ptr_after(w_grant_idx);
            end
         end
         if (w_complete) begin
            r_done <= NUM_PU'(1) << r_id;
            r_ptr  <= ptr_after(r_id);
         end
      end
   end

   // Accept strobe is also held off while reset is asserted, so nothing is
   // acknowledged that the registers cannot capture.
   assign pu_wr_ready = (r_state == IDLE && reset) ? w_grant : '0;
   assign pu_wr_done  = r_done;
   assign wr_req      = (r_state == ISSUE);
   assign wr_pu_id    = PU_ID_W'(r_id);
   assign wr_addr     = r_addr;
   assign wr_req_size = r_size;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_dnn_wr_req_arbiter.sv
// tb_dnn_wr_req_arbiter: random PU requesters and a random bridge, checked
// by a transaction-level round-robin model and expectation queues.
module tb_dnn_wr_req_arbiter;
   import dnn_arb_pkg::*;

   localparam int unsigned NPU = 3;
   localparam int unsigned AW  = 32;
   localparam int unsigned SW  = 10;
   localparam int unsigned IDW = pu_id_width(NPU);
   localparam int unsigned TO  = 16;
`ifdef DNN_WR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic [NPU-1:0]     pu_wr_req;
   logic [NPU*AW-1:0]  pu_wr_addr;
   logic [NPU*SW-1:0]  pu_wr_size;
   logic [NPU-1:0]     pu_wr_ready;
   logic [NPU-1:0]     pu_wr_done;
   logic               wr_req;
   logic [IDW-1:0]     wr_pu_id;
   logic [AW-1:0]      wr_addr;
   logic [SW-1:0]      wr_req_size;
   logic               wr_ready;
   logic               wr_done;
   logic               busy;
   logic               timeout_err;

   dnn_wr_req_arbiter #(
      .NUM_PU         (NPU),
      .ADDR_W         (AW),
      .TX_SIZE_WIDTH  (SW),
      .PU_ID_W        (IDW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pu_wr_req   (pu_wr_req),
      .pu_wr_addr  (pu_wr_addr),
      .pu_wr_size  (pu_wr_size),
      .pu_wr_ready (pu_wr_ready),
      .pu_wr_done  (pu_wr_done),
      .wr_req      (wr_req),
      .wr_pu_id    (wr_pu_id),
      .wr_addr     (wr_addr),
      .wr_req_size (wr_req_size),
      .wr_ready    (wr_ready),
      .wr_done     (wr_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            id;
      logic [AW-1:0] addr;
      logic [SW-1:0] size;
   } xfer_t;

   xfer_t bridge_q[$];
   int    done_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit stim_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NPU-1:0] req, input int ptr);
      for (int k = 0; k < NPU; k++) begin
         int i = (ptr + k) % NPU;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   // PU requesters: level requests held until accepted, occasionally withdrawn.
   initial begin : pu_driver
      logic [NPU-1:0] acc;
      pu_wr_req  = '0;
      pu_wr_addr = '0;
      pu_wr_size = '0;
      forever begin
         @(negedge clk);
         acc = pu_wr_ready & pu_wr_req;
         @(posedge clk);
         #1;
         for (int i = 0; i < NPU; i++) begin
            if (acc[i]) begin
               pu_wr_req[i] = 1'b0;
            end else if (pu_wr_req[i]) begin
               if ($urandom_range(0, 19) == 0) pu_wr_req[i] = 1'b0;
            end else if (stim_en && $urandom_range(0, 2) == 0) begin
               pu_wr_req[i] = 1'b1;
               pu_wr_addr[i*AW +: AW] = $urandom();
               pu_wr_size[i*SW +: SW] = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom_range(1, 1023));
            end
         end
      end
   end

   // Bridge: random ready stalls, done after 0..4 cycles (0 = with the handshake),
   // rare long waits, and stray done pulses when nothing is outstanding.
   initial begin : bridge_driver
      bit pend;
      int dly;
      int d;
      pend     = 1'b0;
      dly      = 0;
      wr_ready = 1'b0;
      wr_done  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wr_ready = 1'b0;
         wr_done  = 1'b0;
         if (!reset) begin
            pend = 1'b0;
         end else if (pend) begin
            if (dly == 0) begin
               wr_done = 1'b1;
               pend    = 1'b0;
            end else begin
               dly--;
            end
         end else if (wr_req && $urandom_range(0, 2) == 0) begin
            wr_ready = 1'b1;
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) d = 30;
            if (d == 0) wr_done = 1'b1;
            else begin
               pend = 1'b1;
               dly  = d - 1;
            end
         end else if ($urandom_range(0, 15) == 0) begin
            wr_done = 1'b1;
         end
      end
   end

   // Reference model and scoreboard, evaluated mid-cycle.
   initial begin : monitor
      bit             m_busy;
      bit             m_hs;
      bit             m_terr;
      int             m_ptr;
      int             m_id;
      int             m_acc_cyc;
      int             m_wait_start;
      int             g;
      int             owner;
      logic [NPU-1:0] exp_ready;
      logic [NPU-1:0] exp_done_now;
      logic [NPU-1:0] exp_done_nxt;
      logic [AW-1:0]  a;
      logic [SW-1:0]  s;
      xfer_t          f;
      m_busy = 0; m_hs = 0; m_terr = 0; m_ptr = 0; m_id = 0;
      m_acc_cyc = 0; m_wait_start = 0; exp_done_now = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            check("reset_outputs",
                  64'({pu_wr_ready, pu_wr_done, wr_req, wr_pu_id, wr_addr, wr_req_size, busy, timeout_err}),
                  64'd0);
            m_busy = 0; m_hs = 0; m_terr = 0; m_ptr = 0;
            exp_done_now = '0;
            bridge_q.delete();
            done_q.delete();
         end else begin
            if (pu_wr_done != '0 || exp_done_now != '0)
               check("done_timing", 64'(pu_wr_done), 64'(exp_done_now));
            if (pu_wr_done != '0) begin
               check("done_pending", 64'(done_q.size() != 0), 64'd1);
               if (done_q.size() != 0) begin
                  owner = done_q.pop_front();
                  check("done_owner", 64'(pu_wr_done), 64'(NPU'(1) << owner));
               end
            end

            g = m_busy ? -1 : rr_pick(pu_wr_req, m_ptr);
            exp_ready = (g >= 0) ? NPU'(1) << g : '0;
            check("grant", 64'(pu_wr_ready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(m_busy && cyc > m_acc_cyc));
            check("wr_req", 64'(wr_req), 64'(m_busy && cyc > m_acc_cyc && !m_hs));
            check("timeout_err", 64'(timeout_err), 64'(m_terr));
            if (wr_req && bridge_q.size() != 0) begin
               f = bridge_q[0];
               check("bridge_fields", 64'({wr_pu_id, wr_addr, wr_req_size}),
                     64'({IDW'(f.id), f.addr, f.size}));
            end

            exp_done_nxt = '0;
            if (g >= 0) begin
               a = pu_wr_addr[g*AW +: AW];
               s = pu_wr_size[g*SW +: SW];
               done_q.push_back(g);
               if (s == '0) begin
                  exp_done_nxt = NPU'(1) << g;
                  m_ptr = (g + 1) % NPU;
               end else begin
                  m_busy = 1; m_hs = 0; m_id = g; m_acc_cyc = cyc;
                  bridge_q.push_back('{g, a, s});
               end
            end else if (m_busy && cyc > m_acc_cyc) begin
               if (!m_hs) begin
                  if (wr_ready) begin
                     m_hs = 1;
                     m_wait_start = cyc + 1;
                     if (bridge_q.size() != 0) void'(bridge_q.pop_front());
                     if (wr_done) begin
                        exp_done_nxt = NPU'(1) << m_id;
                        m_ptr = (m_id + 1) % NPU;
                        m_busy = 0; m_hs = 0;
                     end
                  end
               end else if (wr_done) begin
                  exp_done_nxt = NPU'(1) << m_id;
                  m_ptr = (m_id + 1) % NPU;
                  m_busy = 0; m_hs = 0;
               end else if (TO_EN && cyc - m_wait_start == TO - 1) begin
                  exp_done_nxt = NPU'(1) << m_id;
                  m_ptr = (m_id + 1) % NPU;
                  m_busy = 0; m_hs = 0; m_terr = 1;
               end
            end
            exp_done_now = exp_done_nxt;
         end
      end
   end

   initial begin : main
      int t;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      stim_en = 1'b1;
      repeat (1500) @(posedge clk);

      // Abort an in-flight write while it waits for completion.
      t = 0;
      @(negedge clk);
      while (!(busy && !wr_req) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("reach_wait_done", 64'(t < 500), 64'd1);
      #2 reset = 1'b0;
      #1 check("reset_async",
               64'({pu_wr_ready, pu_wr_done, wr_req, wr_pu_id, wr_addr, wr_req_size, busy, timeout_err}),
               64'd0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;

      repeat (1500) @(posedge clk);
      stim_en = 1'b0;

      t = 0;
      @(negedge clk);
      while ((busy || pu_wr_req != '0 || done_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(t < 3000), 64'd1);
      repeat (5) @(posedge clk);
      check("bridge_q_empty", 64'(bridge_q.size()), 64'd0);
      check("done_q_empty", 64'(done_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
